// File: rtl/fp_pkg.sv
// Shared types and helpers for the pipelined floating-point multiplier:
// operand classes, special-result codes, flag positions and field helpers.
package fp_pkg;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } fp_class_e;

    typedef enum logic [1:0] {
        SPC_NONE,
        SPC_QNAN,
        SPC_INF,
        SPC_ZERO
    } fp_special_e;

    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    localparam int               MAX_W = 64;
    localparam logic [MAX_W-1:0] ONE   = 64'd1;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic logic [MAX_W-1:0] exp_field(input logic [MAX_W-1:0] x,
                                                   input int exp_w, input int man_w);
        return (x >> man_w) & ((ONE << exp_w) - ONE);
    endfunction

    function automatic logic [MAX_W-1:0] frac_field(input logic [MAX_W-1:0] x,
                                                    input int man_w);
        return x & ((ONE << man_w) - ONE);
    endfunction

    // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set.
    function automatic logic [MAX_W-1:0] qnan(input int exp_w, input int man_w);
        return (((ONE << exp_w) - ONE) << man_w) | (ONE << (man_w - 1));
    endfunction

    // Denormals classify as zero: the datapath flushes them.
    function automatic fp_class_e classify(input logic exp_zero, input logic exp_ones,
                                           input logic frac_zero);
        if (exp_zero)  return CLS_ZERO;
        if (!exp_ones) return CLS_NORM;
        return frac_zero ? CLS_INF : CLS_NAN;
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Final-stage combinational logic: normalise the mantissa product, round
// (RNE or truncate), apply range limits and special results, and pack.
module fp_round_pack
    import fp_pkg::*;
#(
    parameter int EXP_W    = 8,
    parameter int MAN_W    = 23,
    parameter int ROUND_EN = 1
) (
    input  logic                        sign,
    input  fp_special_e                 spec,
    input  logic signed [EXP_W+1:0]     esum,
    input  logic [2*MAN_W+1:0]          prod,
    output logic [EXP_W+MAN_W:0]        p,
    output logic [3:0]                  flags
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;
    localparam int EW = EXP_W + 2;

    localparam logic [W-1:0]          QNAN    = W'(qnan(EXP_W, MAN_W));
    localparam logic signed [EW-1:0]  EXP_MAX = EW'((1 << EXP_W) - 1);

    logic [PW-2:0]          norm;
    logic signed [EW-1:0]   exp_n;
    logic signed [EW-1:0]   exp_r;
    logic [MAN_W-1:0]       frac;
    logic                   guard;
    logic                   sticky;
    logic                   rnd_up;
    logic [MAN_W:0]         frac_r;

    // NOTE: every output of a combinational block gets a default at the top,
    // so no path can leave a value unassigned and infer a latch.
    always_comb begin
        norm   = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
        exp_n  = prod[PW-1] ? esum + EW'(1) : esum;
        frac   = norm[PW-2 -: MAN_W];
        guard  = norm[PW-2-MAN_W];
        sticky = |norm[PW-3-MAN_W:0];
        rnd_up = (ROUND_EN != 0) && guard && (sticky || frac[0]);
        frac_r = {1'b0, frac} + (MAN_W+1)'(rnd_up);
        // A carry out of the fraction leaves it all-zero: bump the exponent.
        exp_r  = exp_n + $signed({{(EW-1){1'b0}}, frac_r[MAN_W]});

        p     = '0;
        flags = '0;
        unique case (spec)
            SPC_QNAN: begin
                p                   = QNAN;
                flags[FLAG_INVALID] = 1'b1;
            end
            SPC_INF:  p = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            SPC_ZERO: p = {sign, {(W-1){1'b0}}};
            default: begin
                if (exp_r >= EXP_MAX) begin
                    p                    = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    flags[FLAG_OVERFLOW] = 1'b1;
                    flags[FLAG_INEXACT]  = 1'b1;
                end else if (exp_r <= 0) begin
                    p                     = {sign, {(W-1){1'b0}}};
                    flags[FLAG_UNDERFLOW] = 1'b1;
                    flags[FLAG_INEXACT]   = 1'b1;
                end else begin
                    p                   = {sign, exp_r[EXP_W-1:0], frac_r[MAN_W-1:0]};
                    flags[FLAG_INEXACT] = guard | sticky;
                end
            end
        endcase
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage floating-point multiplier with a valid/ready handshake:
// unpack/classify, mantissa multiply, normalise/round/pack. Global stall.
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W    = 8,
    parameter int MAN_W    = 23,
    parameter int ROUND_EN = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     a,
    input  logic [EXP_W+MAN_W:0]     b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     p,
    output logic [3:0]               flags
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;
    localparam int EW = EXP_W + 2;

    localparam logic signed [EW-1:0] BIAS = EW'(bias(EXP_W));

    logic                   advance;
    logic [EXP_W-1:0]       ea, eb;
    logic [MAN_W-1:0]       fa, fb;
    fp_class_e              cls_a, cls_b;
    fp_special_e            spec_d;

    logic                   s1_valid, s1_sign;
    fp_special_e            s1_spec;
    logic signed [EW-1:0]   s1_esum;
    logic [MAN_W:0]         s1_ma, s1_mb;

    logic                   s2_valid, s2_sign;
    fp_special_e            s2_spec;
    logic signed [EW-1:0]   s2_esum;
    logic [PW-1:0]          s2_prod;

    logic [W-1:0]           rp_p;
    logic [3:0]             rp_flags;

    // Every stage moves together; nothing advances while the output is blocked.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    assign ea    = EXP_W'(exp_field(MAX_W'(a), EXP_W, MAN_W));
    assign eb    = EXP_W'(exp_field(MAX_W'(b), EXP_W, MAN_W));
    assign fa    = MAN_W'(frac_field(MAX_W'(a), MAN_W));
    assign fb    = MAN_W'(frac_field(MAX_W'(b), MAN_W));
    assign cls_a = classify(ea == '0, ea == '1, fa == '0);
    assign cls_b = classify(eb == '0, eb == '1, fb == '0);

    always_comb begin
        spec_d = SPC_NONE;
        if (cls_a == CLS_NAN || cls_b == CLS_NAN ||
            (cls_a == CLS_ZERO && cls_b == CLS_INF) ||
            (cls_a == CLS_INF && cls_b == CLS_ZERO))
            spec_d = SPC_QNAN;
        else if (cls_a == CLS_INF || cls_b == CLS_INF)
            spec_d = SPC_INF;
        else if (cls_a == CLS_ZERO || cls_b == CLS_ZERO)
            spec_d = SPC_ZERO;
    end

    // NOTE: registers use non-blocking assignments so every stage samples the
    // previous stage's old value on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_spec   <= SPC_NONE;
            s1_esum   <= '0;
            s1_ma     <= '0;
            s1_mb     <= '0;
            s2_valid  <= 1'b0;
            s2_sign   <= 1'b0;
            s2_spec   <= SPC_NONE;
            s2_esum   <= '0;
            s2_prod   <= '0;
            out_valid <= 1'b0;
            p         <= '0;
            flags     <= '0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            s1_sign   <= a[W-1] ^ b[W-1];
            s1_spec   <= spec_d;
            s1_esum   <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
            s1_ma     <= {1'b1, fa};
            s1_mb     <= {1'b1, fb};

            s2_valid  <= s1_valid;
            s2_sign   <= s1_sign;
            s2_spec   <= s1_spec;
            s2_esum   <= s1_esum;
            s2_prod   <= PW'(s1_ma) * PW'(s1_mb);

            out_valid <= s2_valid;
            p         <= rp_p;
            flags     <= rp_flags;
        end
    end

    fp_round_pack #(
        .EXP_W    (EXP_W),
        .MAN_W    (MAN_W),
        .ROUND_EN (ROUND_EN)
    ) u_round_pack (
        .sign  (s2_sign),
        .spec  (s2_spec),
        .esum  (s2_esum),
        .prod  (s2_prod),
        .p     (rp_p),
        .flags (rp_flags)
    );

endmodule
